// File: rtl/ysyx_22051013_mdu.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22051013_mdu
// Purpose  : Iterative RV64M multiply/divide unit for the execute stage.
//            Radix-2 shift-add multiplier and restoring divider, one bit per
//            cycle. MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU plus W variants.
// Ports    : clk, rst (sync, active-high)
//            in_valid/in_ready      - request handshake (mdu_op, op1, op2)
//            flush                  - squash whatever is in flight
//            out_valid/out_ready    - result handshake (out_res)
//            busy                   - unit is not idle
// Options  : YSYX_22051013_MDU_FAST_EN - when defined, divide-by-zero,
//            signed overflow, multiply by zero and |dividend| < |divisor|
//            complete one cycle after acceptance instead of iterating.
//            Results are identical either way.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22051013_mdu #(
    parameter int XLEN = 64,
    parameter int OP_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] mdu_op,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_res,
    output logic            busy
);

    localparam int c_cnt_w = $clog2(XLEN + 1);
    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_calc = 2'd1;
    localparam logic [1:0] c_done = 2'd2;
    localparam logic [XLEN-1:0] c_min_x = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] c_min_w = {{(XLEN-31){1'b1}}, 31'b0};

    function automatic logic [XLEN-1:0] f_sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    // Final result assembly shared by the iterative and the early-out paths.
    // acc holds the product (mul) or the remainder in its low half (div/rem).
    function automatic logic [XLEN-1:0] f_fixup(
        input logic            is_w,
        input logic            is_mul,
        input logic            is_div,
        input logic            is_rem,
        input logic            hi,
        input logic            neg,
        input logic            sign_a,
        input logic            dz,
        input logic            ovf,
        input logic [XLEN-1:0] a,
        input logic [2*XLEN-1:0] acc,
        input logic [XLEN-1:0] q
    );
        logic [2*XLEN-1:0] p;
        logic [XLEN-1:0]   qs;
        logic [XLEN-1:0]   rs;
        logic [XLEN-1:0]   res;
        res = '0;
        p   = neg ? -acc : acc;
        qs  = neg ? -q : q;
        rs  = sign_a ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        if (is_mul) begin
            res = is_w ? f_sext32(p[31:0]) : (hi ? p[2*XLEN-1:XLEN] : p[XLEN-1:0]);
        end else if (is_div) begin
            if (dz)       res = '1;
            else if (ovf) res = a;
            else          res = is_w ? f_sext32(qs[31:0]) : qs;
        end else if (is_rem) begin
            if (dz)       res = is_w ? f_sext32(a[31:0]) : a;
            else if (ovf) res = '0;
            else          res = is_w ? f_sext32(rs[31:0]) : rs;
        end
        return res;
    endfunction

    // ---------------- request decode ----------------
    logic w_is_w, w_is_mul, w_is_div, w_is_rem, w_hi, w_s1, w_s2;

    always_comb begin
        w_is_w   = 1'b0;
        w_is_mul = 1'b0;
        w_is_div = 1'b0;
        w_is_rem = 1'b0;
        w_hi     = 1'b0;
        w_s1     = 1'b0;
        w_s2     = 1'b0;
        case (mdu_op)
            OP_W'(0):  begin w_is_mul = 1'b1; w_s1 = 1'b1; w_s2 = 1'b1; end
            OP_W'(1):  begin w_is_mul = 1'b1; w_hi = 1'b1; w_s1 = 1'b1; w_s2 = 1'b1; end
            OP_W'(2):  begin w_is_mul = 1'b1; w_hi = 1'b1; w_s1 = 1'b1; end
            OP_W'(3):  begin w_is_mul = 1'b1; w_hi = 1'b1; end
            OP_W'(4):  begin w_is_div = 1'b1; w_s1 = 1'b1; w_s2 = 1'b1; end
            OP_W'(5):  begin w_is_div = 1'b1; end
            OP_W'(6):  begin w_is_rem = 1'b1; w_s1 = 1'b1; w_s2 = 1'b1; end
            OP_W'(7):  begin w_is_rem = 1'b1; end
            OP_W'(8):  begin w_is_mul = 1'b1; w_is_w = 1'b1; w_s1 = 1'b1; w_s2 = 1'b1; end
            OP_W'(9):  begin w_is_div = 1'b1; w_is_w = 1'b1; w_s1 = 1'b1; w_s2 = 1'b1; end
            OP_W'(10): begin w_is_div = 1'b1; w_is_w = 1'b1; end
            OP_W'(11): begin w_is_rem = 1'b1; w_is_w = 1'b1; w_s1 = 1'b1; w_s2 = 1'b1; end
            OP_W'(12): begin w_is_rem = 1'b1; w_is_w = 1'b1; end
            default:   ; // illegal: no class flag set, result forced to 0
        endcase
    end

    // W ops work on the low words, extended so that full-width magnitude
    // logic handles them unchanged.
    logic [XLEN-1:0]    w_a, w_b, w_ma, w_mb;
    logic               w_sign_a, w_sign_b, w_neg, w_dz, w_ovf;
    logic [c_cnt_w-1:0] w_n;

    assign w_a      = w_is_w ? (w_s1 ? f_sext32(op1[31:0]) : XLEN'(op1[31:0])) : op1;
    assign w_b      = w_is_w ? (w_s2 ? f_sext32(op2[31:0]) : XLEN'(op2[31:0])) : op2;
    assign w_sign_a = w_s1 & w_a[XLEN-1];
    assign w_sign_b = w_s2 & w_b[XLEN-1];
    assign w_neg    = w_sign_a ^ w_sign_b;
    assign w_ma     = w_sign_a ? -w_a : w_a;
    assign w_mb     = w_sign_b ? -w_b : w_b;
    assign w_dz     = (w_is_div | w_is_rem) & (w_b == '0);
    assign w_ovf    = (w_is_div | w_is_rem) & w_s1 & (w_b == '1)
                    & (w_a == (w_is_w ? c_min_w : c_min_x));
    assign w_n      = w_is_w ? c_cnt_w'(32) : c_cnt_w'(XLEN);

`ifdef YSYX_22051013_MDU_FAST_EN
    logic              w_fast;
    logic [2*XLEN-1:0] w_fast_acc;
    assign w_fast     = w_is_mul ? ((w_a == '0) || (w_b == '0))
                                 : ((w_is_div | w_is_rem) & (w_dz | w_ovf | (w_ma < w_mb)));
    // Early-out equivalent of the iterated state: zero product, or zero
    // quotient with the whole dividend magnitude left as remainder.
    assign w_fast_acc = w_is_mul ? '0 : {{XLEN{1'b0}}, w_ma};
`endif

    // ---------------- state ----------------
    logic [1:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [XLEN-1:0]    r_res;
    logic [XLEN-1:0]    r_a;
    logic [2*XLEN-1:0]  r_acc;    // product accumulator / remainder (low half)
    logic [2*XLEN-1:0]  r_mcand;  // shifting multiplicand / static divisor
    logic [XLEN-1:0]    r_q;      // multiplier bits / dividend-in, quotient-out
    logic r_is_w, r_is_mul, r_is_div, r_is_rem, r_hi, r_neg, r_sign_a, r_dz, r_ovf;

    // ---------------- one iteration ----------------
    logic [2*XLEN-1:0] w_acc_nxt, w_mcand_nxt;
    logic [XLEN-1:0]   w_q_nxt;
    logic [XLEN:0]     w_rsh, w_rdiff;
    logic              w_ge;

    always_comb begin
        w_rsh       = {r_acc[XLEN-1:0], r_q[XLEN-1]};
        w_rdiff     = w_rsh - {1'b0, r_mcand[XLEN-1:0]};
        // Borrow out of the trial subtraction means the divisor did not fit.
        w_ge        = ~w_rdiff[XLEN];
        w_acc_nxt   = r_acc;
        w_mcand_nxt = r_mcand;
        w_q_nxt     = r_q;
        if (r_is_mul) begin
            w_acc_nxt   = r_acc + (r_q[0] ? r_mcand : '0);
            w_mcand_nxt = r_mcand << 1;
            w_q_nxt     = r_q >> 1;
        end else begin
            w_acc_nxt = {{XLEN{1'b0}}, (w_ge ? w_rdiff[XLEN-1:0] : w_rsh[XLEN-1:0])};
            w_q_nxt   = {r_q[XLEN-2:0], w_ge};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_idle;
            r_cnt    <= '0;
            r_res    <= '0;
            r_a      <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_q      <= '0;
            r_is_w   <= 1'b0;
            r_is_mul <= 1'b0;
            r_is_div <= 1'b0;
            r_is_rem <= 1'b0;
            r_hi     <= 1'b0;
            r_neg    <= 1'b0;
            r_sign_a <= 1'b0;
            r_dz     <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (flush) begin
            r_state <= c_idle;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_idle: if (in_valid) begin
                    r_is_w   <= w_is_w;
                    r_is_mul <= w_is_mul;
                    r_is_div <= w_is_div;
                    r_is_rem <= w_is_rem;
                    r_hi     <= w_hi;
                    r_neg    <= w_neg;
                    r_sign_a <= w_sign_a;
                    r_dz     <= w_dz;
                    r_ovf    <= w_ovf;
                    r_a      <= w_a;
                    r_acc    <= '0;
                    r_mcand  <= w_is_mul ? {{XLEN{1'b0}}, w_ma} : {{XLEN{1'b0}}, w_mb};
                    // A W dividend is left-aligned so its MSB is consumed first.
                    r_q      <= w_is_mul ? w_mb : (w_is_w ? (w_ma << (XLEN - 32)) : w_ma);
`ifdef YSYX_22051013_MDU_FAST_EN
                    if (w_fast) begin
                        r_res   <= f_fixup(w_is_w, w_is_mul, w_is_div, w_is_rem, w_hi, w_neg,
                                           w_sign_a, w_dz, w_ovf, w_a, w_fast_acc, '0);
                        r_cnt   <= '0;
                        r_state <= c_done;
                    end else
`endif
                    begin
                        r_cnt   <= w_n;
                        r_state <= c_calc;
                    end
                end
                c_calc: begin
                    r_acc   <= w_acc_nxt;
                    r_mcand <= w_mcand_nxt;
                    r_q     <= w_q_nxt;
                    r_cnt   <= r_cnt - c_cnt_w'(1);
                    if (r_cnt == c_cnt_w'(1)) begin
                        r_res   <= f_fixup(r_is_w, r_is_mul, r_is_div, r_is_rem, r_hi, r_neg,
                                           r_sign_a, r_dz, r_ovf, r_a, w_acc_nxt, w_q_nxt);
                        r_state <= c_done;
                    end
                end
                c_done: if (out_ready) r_state <= c_idle;
                default: r_state <= c_idle;
            endcase
        end
    end

    assign in_ready  = (r_state == c_idle) & ~rst;
    assign out_valid = (r_state == c_done);
    assign out_res   = r_res;
    assign busy      = (r_state != c_idle);

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22051013_mdu.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_22051013_mdu
// Purpose  : Directed self-checking bench for ysyx_22051013_mdu: results,
//            latency, output hold, flush and reset behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_22051013_mdu;

`ifdef YSYX_22051013_MDU_FAST_EN
    localparam int c_lat_sp   = 1;
    localparam int c_lat_sp_w = 1;
`else
    localparam int c_lat_sp   = 65;
    localparam int c_lat_sp_w = 33;
`endif
    localparam int c_lat_x = 65;
    localparam int c_lat_w = 33;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  mdu_op;
    logic [63:0] op1;
    logic [63:0] op2;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_res;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ysyx_22051013_mdu #(.XLEN(64), .OP_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mdu_op   (mdu_op),
        .op1      (op1),
        .op2      (op2),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_res  (out_res),
        .busy     (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request from IDLE, measure latency, optionally hold out_ready
    // low for some cycles, then retire it.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp_res,
                          input int exp_lat, input int hold);
        int   lat;
        logic calc_bad;
        logic hold_bad;
        check({tag, " in_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        mdu_op   = op;
        op1      = a;
        op2      = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat      = 1;
        calc_bad = 1'b0;
        while (!out_valid && lat < 200) begin
            if (in_ready || !busy) calc_bad = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " result"}, out_res, exp_res);
        check({tag, " busy"}, 64'(calc_bad), 64'd0);
        if (hold > 0) begin
            hold_bad = 1'b0;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                if (!out_valid || out_res !== exp_res || in_ready) hold_bad = 1'b1;
            end
            check({tag, " hold"}, 64'(hold_bad), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, " retire"}, 64'({out_valid, busy}), 64'd0);
    endtask

    initial begin
        logic seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        mdu_op    = 4'd0;
        op1       = '0;
        op2       = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst in_ready", 64'(in_ready), 64'd0);
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst out_res", out_res, 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        rst = 1'b0;
        #1;
        check("post-rst in_ready", 64'(in_ready), 64'd1);

        run_op("MUL", 4'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, c_lat_x, 5);
        run_op("MULHU", 4'd3, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, c_lat_x, 0);
        run_op("MULHSU", 4'd2, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, c_lat_x, 0);
        run_op("MULH", 4'd1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
               64'h4000_0000_0000_0000, c_lat_x, 0);
        run_op("DIV", 4'd4, -64'd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, c_lat_x, 0);
        run_op("REM", 4'd6, -64'd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, c_lat_x, 0);
        run_op("DIVU", 4'd5, 64'd100, 64'd7, 64'd14, c_lat_x, 0);
        run_op("REMU", 4'd7, 64'd100, 64'd7, 64'd2, c_lat_x, 0);
        run_op("DIVU/0", 4'd5, 64'd5, 64'd0, '1, c_lat_sp, 0);
        run_op("REM/0", 4'd6, 64'd5, 64'd0, 64'd5, c_lat_sp, 0);
        run_op("DIV-/0", 4'd4, -64'd5, 64'd0, '1, c_lat_sp, 0);
        run_op("DIV ovf", 4'd4, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, c_lat_sp, 0);
        run_op("REM ovf", 4'd6, 64'h8000_0000_0000_0000, '1, 64'd0, c_lat_sp, 0);
        run_op("DIV small", 4'd4, 64'd3, 64'd10, 64'd0, c_lat_sp, 0);
        run_op("REM small", 4'd6, -64'd3, 64'd10, 64'hFFFF_FFFF_FFFF_FFFD, c_lat_sp, 0);
        run_op("MUL zero", 4'd0, 64'd0, 64'd5, 64'd0, c_lat_sp, 0);
        run_op("DIVW ovf", 4'd9, 64'h0000_0001_8000_0000, '1, 64'hFFFF_FFFF_8000_0000, c_lat_sp_w, 0);
        run_op("REMUW", 4'd12, 64'h0000_0001_0000_0007, 64'd3, 64'd1, c_lat_w, 0);
        run_op("MULW", 4'd8, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, c_lat_w, 0);
        run_op("REMW", 4'd11, 64'h0000_0000_FFFF_FFF9, 64'd2, '1, c_lat_w, 0);
        run_op("DIVUW", 4'd10, 64'h0000_0000_FFFF_FFFF, 64'd1, '1, c_lat_w, 3);
        run_op("illegal", 4'd13, 64'd5, 64'd3, 64'd0, c_lat_x, 0);
        run_op("MUL big", 4'd0, 64'h0000_0001_0000_0003, 64'h0000_0000_0000_0005,
               64'h0000_0005_0000_000F, c_lat_x, 0);

        // flush together with in_valid: nothing is accepted
        in_valid = 1'b1;
        flush    = 1'b1;
        mdu_op   = 4'd5;
        op1      = 64'd100;
        op2      = 64'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush+valid busy", 64'(busy), 64'd0);

        // flush in the tenth CALC cycle
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("pre-flush busy", 64'(busy), 64'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush in_ready", 64'(in_ready), 64'd1);
        check("flush out_valid", 64'(out_valid), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 70; i++) begin
            @(posedge clk); #1;
            if (out_valid || busy) seen = 1'b1;
        end
        check("flush no result", 64'(seen), 64'd0);

        // reset in the middle of CALC (out_res still holds the last result)
        in_valid = 1'b1;
        mdu_op   = 4'd0;
        op1      = 64'd3;
        op2      = 64'd5;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst in_ready", 64'(in_ready), 64'd0);
        check("midrst out_valid", 64'(out_valid), 64'd0);
        check("midrst out_res", out_res, 64'd0);
        check("midrst busy", 64'(busy), 64'd0);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 70; i++) begin
            @(posedge clk); #1;
            if (out_valid || busy) seen = 1'b1;
        end
        check("midrst no result", 64'(seen), 64'd0);

        run_op("recover DIVU", 4'd5, 64'd1000, 64'd10, 64'd100, c_lat_x, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ysyx_22051013_mdu.md
Name: ysyx_22051013_mdu

Overview:
- Parametrised iterative multiply/divide unit for the pipeline execute stage.
- Takes over RV64M work from the single-cycle ALU: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU plus W variants.
- Radix-2 shift-add multiplier and restoring divider, one bit per cycle.
- valid/ready handshake on both sides; flush input for pipeline squash.

Parameters:
- XLEN, 64: operand/result width. W ops are legal only when XLEN==64.
- OP_W, 4: width of mdu_op.

Ports:
- clk, input, 1: clock. All state updates on the rising edge.
- rst, input, 1: synchronous reset, active-high.
- in_valid, input, 1: request valid.
- in_ready, output, 1: unit can accept a request.
- mdu_op, input, OP_W: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU, 8 MULW, 9 DIVW, 10 DIVUW, 11 REMW, 12 REMUW. Other codes are illegal.
- op1, input, XLEN: rs1 value / dividend.
- op2, input, XLEN: rs2 value / divisor.
- flush, input, 1: squash the in-flight operation.
- out_valid, output, 1: result valid.
- out_ready, input, 1: consumer accepts the result.
- out_res, output, XLEN: result.
- busy, output, 1: state != IDLE.

Behaviour:
- Reset (rst=1 at an edge):
  - state goes to IDLE; out_valid=0; out_res=0; counter=0; all datapath registers cleared.
  - in_ready=0 while rst is high, 1 in IDLE afterwards.
  - Reset mid-operation abandons it and emits no result.
- States:
  - IDLE: in_ready=1. in_valid & ~flush latches op, operands and sign info, then goes to CALC with counter=N. N=XLEN for full ops, 32 for W ops.
  - CALC: one iteration per cycle, counter decrements. When counter reaches 1, the final fix-up (sign correction, W sign-extension, H/low select) is registered into out_res and the state goes to DONE.
  - DONE: out_valid=1 and out_res held stable until out_ready=1. On out_valid & out_ready, go to IDLE.
- Latency:
  - Accept edge, then N CALC cycles; out_valid is high from the cycle after the last CALC cycle.
  - A full op gives out_valid on the (N+1)th cycle after acceptance.
  - There is no back-to-back overlap: a new accept requires IDLE.
- flush:
  - In any state, the next state is IDLE and out_valid drops next cycle.
  - flush overrides in_valid in the same cycle (no accept).
  - flush overrides out_ready in DONE (the result is treated as discarded).
- Multiply:
  - Signed operands are converted to magnitudes; an unsigned 2*XLEN product is accumulated; the product is negated if the signs differ.
  - MULHSU: op1 signed, op2 unsigned.
  - MUL returns product[XLEN-1:0]; MULH* return product[2*XLEN-1:XLEN].
- Divide:
  - Magnitudes go through a restoring divider.
  - Quotient is negated if the signs differ; remainder takes the sign of the dividend.
- W ops:
  - Operands are op[31:0], sign-extended (MULW/DIVW/REMW) or zero-extended (DIVUW/REMUW) to 32-bit arithmetic.
  - The 32-bit result is always sign-extended to XLEN.
- Divide by zero:
  - Quotient is all ones.
  - Remainder is the dividend (W: sign-extended 32-bit dividend).
- Signed overflow (most-negative / -1):
  - Quotient is the dividend.
  - Remainder is 0.
  - Applies at XLEN and at 32 bits for DIVW/REMW.
- Illegal mdu_op: accepted, takes XLEN cycles, result 0.

Optional Feature:
- Macro: YSYX_22051013_MDU_FAST_EN.
- Defined: the following complete with CALC skipped, giving out_valid on the cycle after acceptance (latency 1):
  - divide by zero;
  - signed overflow;
  - multiply with either operand equal to 0;
  - divide where |dividend| < |divisor|.
- Not defined: these cases run the full N cycles. Results are bit-identical in both builds.

Test Plan:
- MUL op1=7, op2=0xFFFFFFFFFFFFFFFD -> out_res=0xFFFFFFFFFFFFFFEB, out_valid on cycle 65 after accept, in_ready=0 throughout.
- MULHU op1=op2=0xFFFFFFFFFFFFFFFF -> 0xFFFFFFFFFFFFFFFE. MULHSU op1=-1, op2=2 -> 0xFFFFFFFFFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFFFFFFFFFD. REM -7,2 -> 0xFFFFFFFFFFFFFFFF. DIVU 100/7 -> 14. REMU 100,7 -> 2.
- Corner cases, each with latency 1 when FAST_EN is defined and 65 otherwise:
  - DIVU 5/0 -> 0xFFFFFFFFFFFFFFFF.
  - REM 5,0 -> 5.
  - DIV 0x8000000000000000 / -1 -> 0x8000000000000000.
  - REM of the same operands -> 0.
- W ops, each with 32 CALC cycles:
  - DIVW op1=0x0000000180000000, op2=-1 -> 0xFFFFFFFF80000000.
  - REMUW op1=0x100000007, op2=3 -> 1.
  - MULW 0x7FFFFFFF*2 -> 0xFFFFFFFFFFFFFFFE.
- Handshake:
  - Hold out_ready=0 for 5 cycles in DONE -> out_res stable and out_valid high.
  - flush at CALC cycle 10 -> IDLE/in_ready=1 next cycle, no out_valid.
  - rst mid-CALC -> all outputs at reset values.
